// File: rtl/midi_msg_merger.sv
// Message-aware MIDI merger: per-input byte FIFOs and round-robin arbitration of whole messages.
// Optional lock-starvation timeout is built when MIDI_MERGE_TIMEOUT_EN is defined.
module midi_msg_merger #(
   parameter int unsigned NUM_IN         = 4,
   parameter int unsigned NUM_OUT        = 4,
   parameter int unsigned FIFO_AW        = 3,
   parameter int unsigned TIMEOUT_CYCLES = 65536,
   localparam int unsigned SW            = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [8*NUM_IN-1:0] in_data,
   input  logic [NUM_IN-1:0]   in_valid,
   input  logic [NUM_IN-1:0]   ovf_clr,
   output logic [NUM_IN-1:0]   overflow,
   input  logic [NUM_OUT-1:0]  midi_sel,
   output logic [7:0]          out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NUM_OUT-1:0]  out_port_en,
   output logic [SW-1:0]       out_src
);
   localparam int unsigned DEPTH = 2 ** FIFO_AW;

   typedef enum logic {StIdle, StLock} state_t;

   state_t                 state_q, state_d;
   logic [7:0]             mem_q [NUM_IN][DEPTH];
   logic [FIFO_AW:0]       wr_ptr_q [NUM_IN];
   logic [FIFO_AW:0]       rd_ptr_q [NUM_IN];
   logic [NUM_IN-1:0]      empty, full, pop, wr_en, drop;
   logic [7:0]             head;
   logic [1:0]             len;
   logic [SW-1:0]          rr_q, rr_d, src_q, src_d, grant_idx, next_src;
   logic                   grant_vld, pop_en, done, timeout;
   logic [NUM_IN-1:0][1:0] run_len_q, run_len_d;
   logic [1:0]             rem_q, rem_d;
   logic                   first_q, first_d, sysex_q, sysex_d;
   logic [7:0]             data_q, data_d;
   logic                   valid_q, valid_d;
   logic [NUM_OUT-1:0]     port_en_q, port_en_d;
   logic [NUM_IN-1:0]      ovf_q;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   // Data bytes following a status byte; F0 and realtime are handled by the caller.
   function automatic logic [1:0] msg_len(input logic [7:0] b);
      case (b[7:4])
         4'h8, 4'h9, 4'hA, 4'hB, 4'hE: msg_len = 2'd2;
         4'hC, 4'hD:                   msg_len = 2'd1;
         4'hF: begin
            case (b[3:0])
               4'h2:       msg_len = 2'd2;
               4'h1, 4'h3: msg_len = 2'd1;
               default:    msg_len = 2'd0;
            endcase
         end
         default: msg_len = 2'd0;
      endcase
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
         full[i]  = (wr_ptr_q[i] == (rd_ptr_q[i] ^ {1'b1, {FIFO_AW{1'b0}}}));
      end
   end

   assign head     = mem_q[src_q][rd_ptr_q[src_q][FIFO_AW-1:0]];
   assign len      = msg_len(head);
   assign next_src = (src_q == SW'(NUM_IN - 1)) ? '0 : src_q + 1'b1;
   assign pop_en   = (state_q == StLock) && !empty[src_q] && (!valid_q || out_ready);
   // A pop frees a slot in the same cycle, so a write to a full FIFO still lands.
   assign wr_en    = in_valid & (~full | pop);
   assign drop     = in_valid & ~wr_en;

   always_comb begin
      pop        = '0;
      pop[src_q] = pop_en;
   end

   always_comb begin
      int j;
      logic [SW-1:0] jj;
      grant_vld = 1'b0;
      grant_idx = '0;
      j         = 0;
      jj        = '0;
      // Scan downward so the candidate nearest rr_q is the last one to win.
      for (int k = int'(NUM_IN) - 1; k >= 0; k--) begin
         j = int'(rr_q) + k;
         if (j >= int'(NUM_IN)) j = j - int'(NUM_IN);
         jj = SW'(j);
         if (!empty[jj]) begin
            grant_vld = 1'b1;
            grant_idx = jj;
         end
      end
   end

`ifdef MIDI_MERGE_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_q, to_d;

   always_comb begin
      to_d    = to_q;
      timeout = 1'b0;
      if (state_q != StLock || pop_en) begin
         to_d = '0;
      end else if (empty[src_q]) begin
         if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout = 1'b1;
            to_d    = '0;
         end else begin
            to_d = to_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) to_q <= '0;
      else     to_q <= to_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      src_d     = src_q;
      port_en_d = port_en_q;
      data_d    = data_q;
      valid_d   = valid_q;
      rem_d     = rem_q;
      first_d   = first_q;
      sysex_d   = sysex_q;
      run_len_d = run_len_q;
      done      = 1'b0;
      if (valid_q && out_ready) valid_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (grant_vld && (!valid_q || out_ready)) begin
               state_d   = StLock;
               src_d     = grant_idx;
               port_en_d = midi_sel;
               rem_d     = 2'd0;
               first_d   = 1'b1;
               sysex_d   = 1'b0;
            end
         end
         StLock: begin
            if (pop_en) begin
               data_d  = head;
               valid_d = 1'b1;
               if (head < 8'hF8) begin
                  if (head[7]) begin
                     // Any status byte starts a fresh message under the current grant.
                     first_d          = 1'b0;
                     sysex_d          = (head == 8'hF0);
                     rem_d            = len;
                     done             = (head != 8'hF0) && (len == 2'd0);
                     run_len_d[src_q] = (head[7:4] != 4'hF) ? len : 2'd0;
                  end else if (!sysex_q) begin
                     if (first_q) begin
                        first_d = 1'b0;
                        rem_d   = run_len_q[src_q] - 2'd1;
                        done    = (run_len_q[src_q] <= 2'd1);
                     end else begin
                        rem_d = rem_q - 2'd1;
                        done  = (rem_q <= 2'd1);
                     end
                  end
               end
            end else if (timeout) begin
               done             = 1'b1;
               run_len_d[src_q] = 2'd0;
            end
            if (done) begin
               state_d = StIdle;
               rr_d    = next_src;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         rr_q      <= '0;
         src_q     <= '0;
         port_en_q <= '0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         rem_q     <= 2'd0;
         first_q   <= 1'b0;
         sysex_q   <= 1'b0;
         run_len_q <= '0;
         ovf_q     <= '0;
         for (int i = 0; i < NUM_IN; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         src_q     <= src_d;
         port_en_q <= port_en_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         rem_q     <= rem_d;
         first_q   <= first_d;
         sysex_q   <= sysex_d;
         run_len_q <= run_len_d;
         ovf_q     <= (ovf_q & ~ovf_clr) | drop;
         for (int i = 0; i < NUM_IN; i++) begin
            if (wr_en[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
            if (pop[i])   rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_IN; i++) begin
         if (wr_en[i]) mem_q[i][wr_ptr_q[i][FIFO_AW-1:0]] <= in_data[8*i +: 8];
      end
   end

   assign overflow    = ovf_q;
   assign out_data    = data_q;
   assign out_valid   = valid_q;
   assign out_port_en = port_en_q;
   assign out_src     = src_q;
endmodule

// File: tb/tb_midi_msg_merger.sv
// Directed bench for midi_msg_merger: latency, arbitration, running status, overflow, reset.
// Define MIDI_MERGE_TIMEOUT_EN to also exercise the starvation timeout (TIMEOUT_CYCLES=16).
module tb_midi_msg_merger;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic [3:0]  in_valid, ovf_clr, overflow, midi_sel, out_port_en;
   logic [7:0]  out_data;
   logic        out_valid, out_ready;
   logic [1:0]  out_src;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [7:0] got_data [32];
   logic [1:0] got_src [32];
   logic [3:0] got_en [32];
   int         got_cyc [32];
   int         got_n;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   midi_msg_merger #(
      .NUM_IN(4), .NUM_OUT(4), .FIFO_AW(3), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .ovf_clr(ovf_clr),
      .overflow(overflow), .midi_sel(midi_sel), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_port_en(out_port_en), .out_src(out_src)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input int i, input logic [7:0] b);
      in_data[8*i +: 8] = b;
      in_valid[i]       = 1'b1;
   endtask

   // Records every accepted output byte until n are seen or the budget runs out.
   task automatic collect(input int n, input int budget);
      got_n = 0;
      for (int k = 0; k < 32; k++) begin
         got_data[k] = 8'hxx;
         got_src[k]  = 2'bxx;
         got_en[k]   = 4'bxxxx;
         got_cyc[k]  = 0;
      end
      for (int t = 0; t < budget && got_n < n; t++) begin
         if (out_valid && out_ready) begin
            got_data[got_n] = out_data;
            got_src[got_n]  = out_src;
            got_en[got_n]   = out_port_en;
            got_cyc[got_n]  = cyc;
            got_n++;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (out_data !== 8'h00) begin
         failures++; $display("FAIL reset_data: got %h expected 00", out_data);
      end
      checks++;
      if (out_port_en !== 4'h0) begin
         failures++; $display("FAIL reset_port_en: got %b expected 0000", out_port_en);
      end
      checks++;
      if (out_src !== 2'd0) begin
         failures++; $display("FAIL reset_src: got %0d expected 0", out_src);
      end
      checks++;
      if (overflow !== 4'h0) begin
         failures++; $display("FAIL reset_overflow: got %b expected 0000", overflow);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_note();
      out_ready = 1'b1;
      midi_sel  = 4'b0101;
      strobe(0, 8'h90);
      tick();
      in_valid = '0;
      strobe(0, 8'h3C);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL note_early_c1: got valid %b expected 0", out_valid);
      end
      tick();
      in_valid = '0;
      strobe(0, 8'h64);
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL note_early_c2: got valid %b expected 0", out_valid);
      end
      tick();
      in_valid = '0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h90 || out_port_en !== 4'b0101 || out_src !== 2'd0)
      begin
         failures++;
         $display("FAIL note_c3: got v%b %h en%b src%0d expected v1 90 en0101 src0",
                  out_valid, out_data, out_port_en, out_src);
      end
      midi_sel = 4'b1111;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_port_en !== 4'b0101) begin
         failures++;
         $display("FAIL note_c4: got v%b %h en%b expected v1 3c en0101",
                  out_valid, out_data, out_port_en);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h64 || out_port_en !== 4'b0101) begin
         failures++;
         $display("FAIL note_c5: got v%b %h en%b expected v1 64 en0101",
                  out_valid, out_data, out_port_en);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++; $display("FAIL note_c6: got valid %b expected 0", out_valid);
      end
   endtask

   task automatic test_contention();
      logic [7:0] exp_d [5] = '{8'h80, 8'h40, 8'h00, 8'hC5, 8'h07};
      logic [1:0] exp_s [5] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
      logic [7:0] exp_d2 [4] = '{8'hC1, 8'h06, 8'hC0, 8'h05};
      logic [1:0] exp_s2 [4] = '{2'd3, 2'd3, 2'd0, 2'd0};
      midi_sel = 4'b0011;
      strobe(1, 8'h80); strobe(2, 8'hC5); tick(); in_valid = '0;
      strobe(1, 8'h40); strobe(2, 8'h07); tick(); in_valid = '0;
      strobe(1, 8'h00); tick(); in_valid = '0;
      collect(5, 30);
      checks++;
      if (got_n != 5) begin
         failures++; $display("FAIL contention_count: got %0d bytes expected 5", got_n);
      end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (got_data[k] !== exp_d[k] || got_src[k] !== exp_s[k] || got_en[k] !== 4'b0011) begin
            failures++;
            $display("FAIL contention_byte%0d: got %h src%0d en%b expected %h src%0d en0011",
                     k, got_data[k], got_src[k], got_en[k], exp_d[k], exp_s[k]);
         end
      end
      checks++;
      if (got_cyc[3] - got_cyc[2] != 2) begin
         failures++;
         $display("FAIL contention_gap: got %0d cycles expected 2", got_cyc[3] - got_cyc[2]);
      end
      // rr_ptr now points at input 3, so input 3 beats input 0.
      strobe(0, 8'hC0); strobe(3, 8'hC1); tick(); in_valid = '0;
      strobe(0, 8'h05); strobe(3, 8'h06); tick(); in_valid = '0;
      collect(4, 30);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (got_data[k] !== exp_d2[k] || got_src[k] !== exp_s2[k]) begin
            failures++;
            $display("FAIL rr_order_byte%0d: got %h src%0d expected %h src%0d",
                     k, got_data[k], got_src[k], exp_d2[k], exp_s2[k]);
         end
      end
   endtask

   task automatic test_running_status();
      logic [7:0] seq [6] = '{8'h91, 8'h30, 8'h7F, 8'h30, 8'hF8, 8'h00};
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         strobe(3, seq[k]);
         tick();
         in_valid = '0;
      end
      out_ready = 1'b1;
      collect(6, 30);
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (got_data[k] !== seq[k] || got_src[k] !== 2'd3) begin
            failures++;
            $display("FAIL running_byte%0d: got %h src%0d expected %h src3",
                     k, got_data[k], got_src[k], seq[k]);
         end
      end
      checks++;
      if (got_cyc[3] - got_cyc[2] != 2) begin
         failures++;
         $display("FAIL running_msg_gap: got %0d cycles expected 2", got_cyc[3] - got_cyc[2]);
      end
      checks++;
      if (got_cyc[5] - got_cyc[3] != 2) begin
         failures++;
         $display("FAIL running_one_lock: got %0d cycles expected 2", got_cyc[5] - got_cyc[3]);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] exp_d [11] = '{8'h90, 8'h3C, 8'h64, 8'h90, 8'h01, 8'h02, 8'h03, 8'h04,
                                 8'h05, 8'h06, 8'h07};
      logic [7:0] b;
      int seen;
      out_ready = 1'b0;
      // Lock onto input 1 with its first byte parked, so input 0 is never popped.
      strobe(1, 8'h90); tick(); in_valid = '0;
      strobe(1, 8'h3C); tick(); in_valid = '0;
      strobe(1, 8'h64); tick(); in_valid = '0;
      for (int k = 0; k < 10; k++) begin
         b = (k == 0) ? 8'h90 : 8'(k);
         strobe(0, b);
         tick();
         in_valid = '0;
         if (k == 7) begin
            checks++;
            if (overflow !== 4'b0000) begin
               failures++; $display("FAIL ovf_at_8: got %b expected 0000", overflow);
            end
         end
      end
      checks++;
      if (overflow !== 4'b0001) begin
         failures++; $display("FAIL ovf_set: got %b expected 0001", overflow);
      end
      strobe(0, 8'h0A);
      ovf_clr = 4'b0001;
      tick();
      in_valid = '0;
      checks++;
      if (overflow !== 4'b0001) begin
         failures++; $display("FAIL ovf_clr_vs_drop: got %b expected 0001", overflow);
      end
      tick();
      ovf_clr = '0;
      checks++;
      if (overflow !== 4'b0000) begin
         failures++; $display("FAIL ovf_clear: got %b expected 0000", overflow);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h90 || out_src !== 2'd1) begin
         failures++;
         $display("FAIL ovf_hold: got v%b %h src%0d expected v1 90 src1",
                  out_valid, out_data, out_src);
      end
      out_ready = 1'b1;
      collect(11, 60);
      for (int k = 0; k < 11; k++) begin
         checks++;
         if (got_data[k] !== exp_d[k] || got_src[k] !== ((k < 3) ? 2'd1 : 2'd0)) begin
            failures++;
            $display("FAIL ovf_byte%0d: got %h src%0d expected %h src%0d",
                     k, got_data[k], got_src[k], exp_d[k], (k < 3) ? 1 : 0);
         end
      end
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         if (out_valid) seen++;
         tick();
      end
      checks++;
      if (seen != 0) begin
         failures++; $display("FAIL ovf_no_extra: got %0d valid cycles expected 0", seen);
      end
   endtask

   task automatic test_reset_sysex();
      logic [7:0] sx [4] = '{8'hF0, 8'h01, 8'h02, 8'h03};
      logic [7:0] note [3] = '{8'h90, 8'h3C, 8'h64};
      int seen;
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         strobe(0, sx[k]);
         tick();
         in_valid = '0;
      end
      out_ready = 1'b1;
      collect(2, 20);
      checks++;
      if (got_data[0] !== 8'hF0 || got_data[1] !== 8'h01) begin
         failures++;
         $display("FAIL sysex_head: got %h %h expected f0 01", got_data[0], got_data[1]);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 2'd0 || out_port_en !== 4'h0)
      begin
         failures++;
         $display("FAIL sysex_reset: got v%b %h src%0d en%b expected v0 00 src0 en0000",
                  out_valid, out_data, out_src, out_port_en);
      end
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++; $display("FAIL sysex_flushed: got %0d valid cycles expected 0", seen);
      end
      midi_sel = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         strobe(2, note[k]);
         tick();
         in_valid = '0;
      end
      collect(3, 20);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (got_data[k] !== note[k] || got_src[k] !== 2'd2 || got_en[k] !== 4'b1000) begin
            failures++;
            $display("FAIL post_reset_byte%0d: got %h src%0d en%b expected %h src2 en1000",
                     k, got_data[k], got_src[k], got_en[k], note[k]);
         end
      end
   endtask

`ifdef MIDI_MERGE_TIMEOUT_EN
   task automatic test_timeout();
      logic [7:0] exp_d [4] = '{8'h90, 8'hB0, 8'h07, 8'h40};
      logic [1:0] exp_s [4] = '{2'd0, 2'd1, 2'd1, 2'd1};
      out_ready = 1'b0;
      strobe(0, 8'h90); tick(); in_valid = '0;
      strobe(1, 8'hB0); tick(); in_valid = '0;
      strobe(1, 8'h07); tick(); in_valid = '0;
      strobe(1, 8'h40); tick(); in_valid = '0;
      out_ready = 1'b1;
      collect(4, 80);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (got_data[k] !== exp_d[k] || got_src[k] !== exp_s[k]) begin
            failures++;
            $display("FAIL timeout_byte%0d: got %h src%0d expected %h src%0d",
                     k, got_data[k], got_src[k], exp_d[k], exp_s[k]);
         end
      end
      checks++;
      if (got_cyc[1] - got_cyc[0] < 14) begin
         failures++;
         $display("FAIL timeout_delay: got %0d cycles expected at least 14",
                  got_cyc[1] - got_cyc[0]);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish within 20000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = '0;
      ovf_clr   = '0;
      midi_sel  = '0;
      out_ready = 1'b1;
      test_reset();
      test_single_note();
      test_contention();
      test_running_status();
      test_overflow();
      test_reset_sysex();
`ifdef MIDI_MERGE_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/midi_msg_merger.md
Name: midi_msg_merger

Overview:
- Message-aware MIDI merger; the second-generation replacement for the wire-AND output merge.
- Takes NUM_IN received byte streams, one per UART RX, and buffers each in its own FIFO.
- A round-robin arbiter forwards whole MIDI messages, never interleaving bytes of two messages.
- Output is one byte stream for the shared TX, plus a per-message output-port enable mask.

Parameters:
- NUM_IN, 4, number of MIDI input byte streams.
- NUM_OUT, 4, number of MIDI output ports in the enable mask.
- FIFO_AW, 3, log2 of per-input FIFO depth (depth = 2**FIFO_AW).
- TIMEOUT_CYCLES, 65536, starvation limit while locked; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8*NUM_IN  byte for input i on bits [8i+7:8i].
- in_valid  in  NUM_IN  one-cycle strobe per received byte (no backpressure).
- ovf_clr  in  NUM_IN  clears the matching overflow bit.
- overflow  out  NUM_IN  sticky: a byte was dropped because the FIFO was full.
- midi_sel  in  NUM_OUT  output-port enables; sampled at message start.
- out_data  out  8  merged byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  TX accepts the byte when out_valid && out_ready.
- out_port_en  out  NUM_OUT  midi_sel captured for the message in flight.
- out_src  out  clog2(NUM_IN)  input index of the message in flight.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFOs empty; state IDLE; rr_ptr=0.
  - out_valid=0; out_data=8'h00; out_port_en=0; out_src=0; overflow=0.
  - All per-input run_len=0.
  - Applies mid-message: any partial message is discarded.
- FIFO write:
  - in_valid[i] with FIFO i not full: write.
  - FIFO i full: drop the byte and set overflow[i].
  - ovf_clr[i] and a new drop in the same cycle: overflow[i] stays 1.
  - Simultaneous write and pop on a full FIFO: the pop takes effect first, so the write is accepted.
- Message length L after the status byte:
  - 8n, 9n, An, Bn, En, F2: L=2.
  - Cn, Dn, F1, F3: L=1.
  - F6, F7 (stray), F4, F5: L=0.
  - F0 (SysEx): unbounded until F7.
  - F8–FF (realtime): L=0; never changes run_len and never ends a message.
- State IDLE:
  - Each cycle, grant the first non-empty FIFO searching from rr_ptr upward, with wrap-around.
  - On a grant: go to LOCK, set out_src, latch out_port_en<=midi_sel.
  - No grant: stay in IDLE.
- State LOCK:
  - Pop the granted FIFO when it is non-empty and (!out_valid || out_ready); the popped byte loads out_data and sets out_valid=1.
  - out_valid clears on a handshake with no pop.
  - First byte is a status byte: rem=L; run_len[src]=L for channel-voice status (8n–En), else run_len[src]=0.
  - First byte is a data byte (running status): rem=run_len[src]-1. If run_len=0, forward as a single-byte message.
  - Realtime bytes from the granted FIFO are forwarded and rem is unchanged.
  - A non-realtime status byte arriving mid-message truncates the current message and restarts it as a new message under the same grant.
  - In SysEx, bytes forward until F7.
  - After popping the final byte (rem reaches 0, or F7 in SysEx): go to IDLE and set rr_ptr=src+1 mod NUM_IN.
- Latency: byte strobed in cycle N → out_valid=1 in cycle N+3 (N+1 FIFO non-empty/grant, N+2 pop).
- Overhead: one IDLE cycle between messages.
- Throughput: with out_ready=1, one byte per cycle within a message.
- out_port_en and out_src are stable from the first byte until the last byte's handshake.

Optional Feature:
- Macro: MIDI_MERGE_TIMEOUT_EN.
- When defined:
  - A counter clears on every pop in LOCK.
  - It increments while LOCK holds with the granted FIFO empty.
  - Reaching TIMEOUT_CYCLES forces IDLE with rr_ptr=src+1, set run_len[src]=0, and no byte is emitted.
- When undefined: LOCK waits indefinitely and no counter logic exists.

Test Plan:
- Single note:
  - Stimulus: in0 strobes 90,3C,64 in cycles 0,1,2; out_ready=1; midi_sel=4'b0101.
  - Response: out_data 90,3C,64 with out_valid rising in cycle 3; out_port_en=0101; out_src=0.
- Contention:
  - Stimulus: in1 sends 80,40,00 while in2 sends C5,07 in the same cycles.
  - Response: in1's message complete, then the C5,07 message; no interleave; rr_ptr=2 then 3.
- Running status and realtime:
  - Stimulus: in3 sends 91,30,7F, then 30,00, with F8 inserted between 30 and 00.
  - Response: 91,30,7F forwarded; the 30,F8,00 message is emitted in one lock; run_len stays 2.
- Overflow:
  - Stimulus: with out_ready=0, strobe 10 bytes on in0 (depth 8).
  - Response: 8 stored, 2 dropped, overflow[0]=1; ovf_clr[0] clears it.
- Reset mid-SysEx:
  - Stimulus: rst=1 after F0,01 is emitted.
  - Response: next cycle out_valid=0, FIFOs empty, state IDLE; a later 90,3C,64 forwards normally.
- Timeout (macro defined, TIMEOUT_CYCLES=16):
  - Stimulus: in0 sends 90 only, while in1 has B0,07,40 waiting.
  - Response: after 16 starved cycles the lock releases and in1's message is forwarded.
